// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift/rotate sequencer: operation modes and FSM states.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/usr_next.sv
// Next-state datapath for the shift register; shared by the direct and burst paths.
module usr_next
    import usr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]   mode_i,
    input  logic [N-1:0] q_i,
    input  logic         msb_in_i,
    input  logic         lsb_in_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_next_o
);

    always_comb begin
        q_next_o = q_i;
        case (mode_i)
            MODE_HOLD: q_next_o = q_i;
            MODE_SHR:  q_next_o = {msb_in_i, q_i[N-1:1]};
            MODE_SHL:  q_next_o = {q_i[N-2:0], lsb_in_i};
            MODE_LOAD: q_next_o = d_i;
            MODE_ROR:  q_next_o = {q_i[0], q_i[N-1:1]};
            MODE_ROL:  q_next_o = {q_i[N-2:0], q_i[N-1]};
            MODE_ASR:  q_next_o = {q_i[N-1], q_i[N-1:1]};
            MODE_CLR:  q_next_o = '0;
            default:   q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/usr_seq.sv
// Universal shift/rotate register with a start/count burst sequencer.
// In RUN the latched mode drives the datapath; otherwise the live mode applies when en is set.
module usr_seq
    import usr_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             msb_in,
    input  logic             lsb_in,
    input  logic [N-1:0]     d,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [N-1:0]     q,
    output logic             msb_out,
    output logic             lsb_out,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       mode_q;
    logic [N-1:0]     q_q;
    logic [N-1:0]     q_d;
    logic [2:0]       mode_sel;

    assign mode_sel = (state_q == ST_RUN) ? mode_q : mode;

    usr_next #(.N(N)) u_next (
        .mode_i   (mode_sel),
        .q_i      (q_q),
        .msb_in_i (msb_in),
        .lsb_in_i (lsb_in),
        .d_i      (d),
        .q_next_o (q_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            q_q     <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    q_q   <= q_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1))
                        state_q <= ST_DONE;
                end
                default: begin
                    // start wins over en, and the accepting edge does not shift
                    if (start) begin
                        if (count == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            mode_q  <= mode;
                            cnt_q   <= count;
                            state_q <= ST_RUN;
                        end
                    end else begin
                        if (en)
                            q_q <= q_d;
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign q       = q_q;
    assign msb_out = q_q[N-1];
    assign lsb_out = q_q[0];
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_usr_seq.sv
// Directed bench for usr_seq: direct modes, bursts, ignored inputs, back-to-back and reset abort.
module tb_usr_seq;

    localparam int N     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic             msb_in;
    logic             lsb_in;
    logic [N-1:0]     d;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [N-1:0]     q;
    logic             msb_out;
    logic             lsb_out;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    usr_seq #(.N(N), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .msb_in  (msb_in),
        .lsb_in  (lsb_in),
        .d       (d),
        .start   (start),
        .count   (count),
        .q       (q),
        .msb_out (msb_out),
        .lsb_out (lsb_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        chk({tag, "_q"}, 16'(q), 16'(eq));
        chk({tag, "_busy"}, 16'(busy), 16'(eb));
        chk({tag, "_done"}, 16'(done), 16'(ed));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 3'b000; msb_in = 1'b0; lsb_in = 1'b0;
        d = 8'h00; start = 1'b0; count = '0;
        #7;
        chk_st("reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;

        // direct load and shifts
        en = 1'b1; mode = 3'b011; d = 8'hA5; tick();
        chk("load", 16'(q), 16'h00A5);
        mode = 3'b001; msb_in = 1'b1; tick();
        chk("shr", 16'(q), 16'h00D2);
        chk("msb_out", 16'(msb_out), 16'h1);
        chk("lsb_out", 16'(lsb_out), 16'h0);
        mode = 3'b010; lsb_in = 1'b0; tick();
        chk("shl", 16'(q), 16'h00A4);
        mode = 3'b011; d = 8'h80; tick();
        mode = 3'b110; tick();
        chk("asr", 16'(q), 16'h00C0);
        en = 1'b0; mode = 3'b010; tick();
        chk("en0_hold", 16'(q), 16'h00C0);

        // ROL burst of 3 from 81
        en = 1'b1; mode = 3'b011; d = 8'h81; tick();
        en = 1'b0; start = 1'b1; mode = 3'b101; count = 4'd3; tick();
        start = 1'b0; mode = 3'b000;
        chk_st("rol_acc", 8'h81, 1'b1, 1'b0);
        tick(); chk_st("rol_s1", 8'h03, 1'b1, 1'b0);
        tick(); chk_st("rol_s2", 8'h06, 1'b1, 1'b0);
        tick(); chk_st("rol_fin", 8'h0C, 1'b0, 1'b1);
        tick(); chk_st("rol_idle", 8'h0C, 1'b0, 1'b0);

        // ROR burst of 11 from 81 wraps
        en = 1'b1; mode = 3'b011; d = 8'h81; tick();
        en = 1'b0; start = 1'b1; mode = 3'b100; count = 4'd11; tick();
        start = 1'b0;
        repeat (10) tick();
        chk("ror_busy10", 16'(busy), 16'h1);
        tick();
        chk_st("ror_fin", 8'h30, 1'b0, 1'b1);

        // count=0 burst
        start = 1'b1; mode = 3'b111; count = 4'd0; tick();
        start = 1'b0;
        chk_st("cnt0", 8'h30, 1'b0, 1'b1);
        tick();
        chk_st("cnt0_after", 8'h30, 1'b0, 1'b0);

        // live inputs ignored during RUN, back-to-back start from DONE
        msb_in = 1'b0; start = 1'b1; mode = 3'b001; count = 4'd2; tick();
        mode = 3'b111; en = 1'b1; start = 1'b1; count = 4'd5; tick();
        chk_st("ign_s1", 8'h18, 1'b1, 1'b0);
        tick();
        chk_st("ign_fin", 8'h0C, 1'b0, 1'b1);
        start = 1'b1; mode = 3'b101; count = 4'd1; en = 1'b0; tick();
        start = 1'b0;
        chk_st("b2b_acc", 8'h0C, 1'b1, 1'b0);
        tick();
        chk_st("b2b_fin", 8'h18, 1'b0, 1'b1);
        tick();

        // reset aborts a burst
        en = 1'b1; mode = 3'b011; d = 8'hFF; tick();
        en = 1'b0; start = 1'b1; mode = 3'b001; count = 4'd8; msb_in = 1'b0; tick();
        start = 1'b0;
        repeat (3) tick();
        chk_st("abort_pre", 8'h1F, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_st("abort_rst", 8'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk_st("abort_idle", 8'h00, 1'b0, 1'b0);
        tick();
        chk_st("abort_nodone", 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
